// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage (MEM has priority).
// One bus transaction is outstanding at a time; the block also drives stall flags and a sticky timeout.
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic [31:0]         if_inst_o,
  output logic                if_valid_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wmask_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_valid_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wmask_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                stall_if_o,
  output logic                stall_mem_o,
  output logic                timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  state_t           state_r;
  owner_t           owner_r;
  logic             drop_r;
  logic [CNT_W-1:0] cnt_r;

  logic        pick_mem_s;
  logic        pick_if_s;
  logic        flush_hit_s;
  logic        busy_s;
  logic [31:0] if_word_s;

  assign stall_if_o  = if_req_i & ~if_valid_o;
  assign stall_mem_o = mem_req_i & ~mem_valid_o;

  assign busy_s      = (state_r == ST_REQ) || (state_r == ST_WAIT);
  assign flush_hit_s = if_flush_i && busy_s && (owner_r == OWN_IF);
  assign if_word_s   = bus_addr_o[2] ? bus_rdata_i[63:32] : bus_rdata_i[31:0];

  // Fixed-priority pick in IDLE; a cycle carrying a valid pulse never arbitrates,
  // since the finishing requester has not yet had a chance to drop its request
  always_comb begin
    pick_mem_s = 1'b0;
    pick_if_s  = 1'b0;
    if ((state_r == ST_IDLE) && !if_valid_o && !mem_valid_o) begin
      if (mem_req_i) begin
        pick_mem_s = 1'b1;
      end else if (if_req_i && !if_flush_i) begin
        pick_if_s = 1'b1;
      end else begin
        pick_if_s = 1'b0;
      end
    end else begin
      pick_mem_s = 1'b0;
    end
  end

  // Transaction FSM: latches bus payload, routes the response, tracks drop and timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_IF;
      drop_r      <= 1'b0;
      cnt_r       <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wmask_o <= '0;
      if_inst_o   <= 32'h0;
      if_valid_o  <= 1'b0;
      mem_rdata_o <= '0;
      mem_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      if_valid_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_mem_s) begin
            owner_r     <= OWN_MEM;
            drop_r      <= 1'b0;
            cnt_r       <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_we_i ? mem_wdata_i : '0;
            bus_wmask_o <= mem_we_i ? mem_wmask_i : '0;
            state_r     <= ST_REQ;
          end else if (pick_if_s) begin
            owner_r     <= OWN_IF;
            drop_r      <= 1'b0;
            cnt_r       <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_wmask_o <= '0;
            state_r     <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state_r   <= ST_WAIT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_i) begin
            state_r <= ST_IDLE;
            if (owner_r == OWN_MEM) begin
              mem_rdata_o <= bus_rdata_i;
              mem_valid_o <= 1'b1;
            end else if (!drop_r && !if_flush_i) begin
              // A flush in the response cycle itself also discards the fetch
              if_inst_o  <= if_word_s;
              if_valid_o <= 1'b1;
            end else begin
              if_valid_o <= 1'b0;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bus_req_o <= 1'b0;
        end
      endcase

      if (flush_hit_s) begin
        drop_r <= 1'b1;
      end

      // Timeout only flags; the transaction keeps waiting for the bus
      if (busy_s) begin
        if (cnt_r != TMO_MAX) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        if (cnt_r == TMO_LAST) begin
          timeout_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for contention, flush, timeout and reset; a scoreboard holds expected data.
module tb_mem_port_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = DW / 8;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_flush = 1'b0;
  logic [31:0]   if_inst;
  logic          if_valid;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [MW-1:0] mem_wmask = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [MW-1:0] bus_wmask;
  logic          bus_gnt = 1'b0;
  logic          bus_rvalid = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          stall_if;
  logic          stall_mem;
  logic          timeout;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_inst_o(if_inst), .if_valid_o(if_valid),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_wmask_i(mem_wmask),
    .mem_rdata_o(mem_rdata), .mem_valid_o(mem_valid),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_wmask_o(bus_wmask),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          gnt_dly;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    bit          is_mem;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[5];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input bit is_mem, input logic [63:0] data);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit is_mem, input logic [63:0] act);
    exp_t e;
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("sb_owner", 64'(is_mem), 64'(e.is_mem));
      chk("sb_data", act, e.data);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_req"}, 64'(bus_req), 64'd0);
    chk({tag, "_bus_we"}, 64'(bus_we), 64'd0);
    chk({tag, "_bus_addr"}, bus_addr, 64'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 64'd0);
    chk({tag, "_bus_wmask"}, 64'(bus_wmask), 64'd0);
    chk({tag, "_if_inst"}, 64'(if_inst), 64'd0);
    chk({tag, "_if_valid"}, 64'(if_valid), 64'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(posedge clk); #1;
      ok = bus_req;
      n++;
    end
    chk("bus_req_seen", 64'(ok), 64'd1);
  endtask

  task automatic grant_reply(input int dly, input logic [63:0] rd);
    logic [63:0] a0, d0;
    logic [7:0]  m0;
    logic        w0;
    bit          steady;
    a0 = bus_addr; d0 = bus_wdata; m0 = bus_wmask; w0 = bus_we;
    steady = 1'b1;
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #1;
      if (!bus_req || bus_addr !== a0 || bus_wdata !== d0 || bus_wmask !== m0 || bus_we !== w0)
        steady = 1'b0;
    end
    chk("payload_stable", 64'(steady), 64'd1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    chk("req_drop_after_gnt", 64'(bus_req), 64'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
  endtask

  task automatic expect_valid(input bit is_mem);
    logic        v, ov, st;
    logic [63:0] d;
    string       nm;
    v  = is_mem ? mem_valid : if_valid;
    ov = is_mem ? if_valid : mem_valid;
    st = is_mem ? stall_mem : stall_if;
    d  = is_mem ? mem_rdata : {32'h0, if_inst};
    if (is_mem) nm = "mem_valid_pulse"; else nm = "if_valid_pulse";
    chk(nm, 64'(v), 64'd1);
    chk("other_valid_low", 64'(ov), 64'd0);
    chk("stall_low_on_valid", 64'(st), 64'd0);
    if (v) sb_pop(is_mem, d);
    if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
    @(posedge clk); #1;
    chk("valid_one_cycle", 64'(is_mem ? mem_valid : if_valid), 64'd0);
  endtask

  task automatic do_txn(input vec_t v);
    bit ok;
    @(posedge clk); #1;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
      mem_wdata = v.wdata; mem_wmask = v.wmask;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    sb_push(v.is_mem, v.exp_data);
    wait_req(ok);
    if (ok) begin
      chk("bus_we", 64'(bus_we), 64'(v.we));
      chk("bus_addr", bus_addr, v.addr);
      chk("bus_wmask", 64'(bus_wmask), 64'(v.we ? v.wmask : 8'h00));
      if (v.we) chk("bus_wdata", bus_wdata, v.wdata);
      chk("stall_while_pending", 64'(v.is_mem ? stall_mem : stall_if), 64'd1);
      grant_reply(v.gnt_dly, v.rdata);
      expect_valid(v.is_mem);
    end else begin
      if_req = 1'b0; mem_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          seen;
    vec_t        v;
    //            mem   we    addr                    wdata                   wmask  rdata                   dly  expected
    vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0004, 64'h0,                  8'h00, 64'h1111_2222_3333_4444, 0, 64'h0000_0000_1111_2222};
    vecs[1] = '{1'b0, 1'b0, 64'h0000_0000_8000_0008, 64'h0,                  8'h00, 64'h1111_2222_3333_4444, 0, 64'h0000_0000_3333_4444};
    vecs[2] = '{1'b1, 1'b0, 64'h0000_0000_8000_1000, 64'h0,                  8'hFF, 64'hCAFE_F00D_1234_5678, 1, 64'hCAFE_F00D_1234_5678};
    vecs[3] = '{1'b1, 1'b1, 64'h0000_0000_8000_2008, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h5A5A_5A5A_0000_0001, 3, 64'h5A5A_5A5A_0000_0001};
    vecs[4] = '{1'b0, 1'b0, 64'h0000_0000_8000_0010, 64'h0,                  8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 2, 64'h0000_0000_CCCC_DDDD};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // IF and MEM together: MEM first, IF stalled throughout, then IF served
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h8000_0044;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_1000; mem_wmask = 8'hFF;
    sb_push(1'b1, 64'h0BAD_F00D_0000_0001);
    sb_push(1'b0, 64'h0000_0000_7777_8888);
    wait_req(ok);
    chk("contend_mem_addr", bus_addr, 64'h8000_1000);
    chk("contend_mem_wmask", 64'(bus_wmask), 64'd0);
    chk("contend_stall_if", 64'(stall_if), 64'd1);
    grant_reply(1, 64'h0BAD_F00D_0000_0001);
    chk("contend_stall_if_at_mem_valid", 64'(stall_if), 64'd1);
    expect_valid(1'b1);
    wait_req(ok);
    chk("contend_if_addr", bus_addr, 64'h8000_0044);
    grant_reply(0, 64'h7777_8888_9999_AAAA);
    expect_valid(1'b0);

    // Flush during IF WAIT: response consumed, no valid
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h8000_0020;
    wait_req(ok);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    if_flush = 1'b1;
    @(posedge clk); #1;
    if_flush = 1'b0; if_req = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    chk("flush_no_valid", 64'(if_valid), 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if_valid || bus_req) seen = 1'b1;
    end
    chk("flush_quiet_after", 64'(seen), 64'd0);
    v = '{1'b0, 1'b0, 64'h8000_0024, 64'h0, 8'h00, 64'h1357_9BDF_2468_ACE0, 0, 64'h0000_0000_1357_9BDF};
    do_txn(v);

    // Flush in IDLE blocks IF arbitration
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h8000_0030; if_flush = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus_req) seen = 1'b1;
    end
    chk("flush_idle_blocks", 64'(seen), 64'd0);
    if_flush = 1'b0;
    sb_push(1'b0, 64'h0000_0000_89AB_CDEF);
    wait_req(ok);
    grant_reply(0, 64'h0123_4567_89AB_CDEF);
    expect_valid(1'b0);

    // Timeout: no grant for TMO cycles in REQ
    chk("timeout_clear_before", 64'(timeout), 64'd0);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_3000;
    sb_push(1'b1, 64'h3333_0000_3333_0000);
    wait_req(ok);
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("timeout_not_yet", 64'(timeout), 64'd0);
    @(posedge clk); #1;
    chk("timeout_set", 64'(timeout), 64'd1);
    chk("req_held_in_timeout", 64'(bus_req), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_sticky", 64'(timeout), 64'd1);
    grant_reply(0, 64'h3333_0000_3333_0000);
    expect_valid(1'b1);
    chk("timeout_sticky_after_done", 64'(timeout), 64'd1);

    // Reset mid-WAIT, then a stray rvalid must be ignored
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h8000_0004;
    wait_req(ok);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 64'h9999_8888_7777_6666;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (if_valid || mem_valid || bus_req) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("stray_rvalid_ignored", 64'(seen), 64'd0);
    do_txn(vecs[0]);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
